// File: rtl/max6682_pkg.sv
`default_nettype none
// =====================================================================
// max6682_pkg: scheduler state encoding and sensor reading assembly.
// Rev 1.0
// =====================================================================
package max6682_pkg;

   localparam int RAW_BITS = 11;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_IDLE     = 2'd1,
      ST_XFER     = 2'd2,
      ST_CHECK    = 2'd3
   } state_t;

   // The sensor delivers 11 significant bits MSB-first: all of byte 1, then the top 3 of byte 0.
   function automatic logic [15:0] assemble_value(input logic [7:0] msb, input logic [2:0] lsb_top);
      logic [RAW_BITS-1:0] raw;
      raw = {msb, lsb_top};
      return {{(16-RAW_BITS){1'b0}}, raw};
   endfunction

endpackage
`default_nettype wire

// File: rtl/max6682_interval_timer.sv
`default_nettype none
// =====================================================================
// max6682_interval_timer: loadable down-counter with zero flag.
// Rev 1.0
// =====================================================================
module max6682_interval_timer #(
   parameter int CntWidth = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                dec,
   input  logic [CntWidth-1:0] preset,
   output logic                zero
);

   localparam logic [CntWidth-1:0] ONE = CntWidth'(1);

   logic [CntWidth-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= preset;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/max6682_sample_sched.sv
`default_nettype none
// =====================================================================
// max6682_sample_sched: periodic MAX6682 read, change detection, CPU wake-up.
// Optional SPI watchdog enabled by defining MAX6682_SPI_TIMEOUT_EN.  Rev 1.0
// =====================================================================
module max6682_sample_sched
   import max6682_pkg::*;
#(
   parameter int CntWidth      = 16,
   parameter int TimeoutCycles = 1024
) (
   input  logic                Clk_i,
   input  logic                Reset_n_i,
   input  logic                Enable_i,
   input  logic [CntWidth-1:0] ParamCounterPreset_i,
   input  logic [15:0]         ParamThreshold_i,
   output logic                SPI_FSM_Start_o,
   input  logic                SPI_FSM_Done_i,
   input  logic [7:0]          Byte0_i,
   input  logic [7:0]          Byte1_i,
   output logic [15:0]         SensorValue_o,
   output logic                CpuIntr_o,
   output logic                SpiTimeout_o
);

   if (TimeoutCycles < 2) begin : g_timeout_check
      $error("TimeoutCycles must be at least 2");
   end

   state_t      state, state_nxt;
   logic        load, dec, zero;
   logic        start_nxt, capture, report, abort, wd_expired;
   logic        start_q, intr_q, abort_q;
   logic [15:0] sample, value, threshold;
   logic [16:0] delta, magnitude;
   logic        done_valid;
   logic        unused_lsb;

   assign unused_lsb = ^Byte0_i[4:0];

   max6682_interval_timer #(.CntWidth(CntWidth)) u_timer (
      .clk    (Clk_i),
      .rst_n  (Reset_n_i),
      .load   (load),
      .dec    (dec),
      .preset (ParamCounterPreset_i),
      .zero   (zero)
   );

   // Done coinciding with our own start pulse belongs to no transfer of ours.
   assign done_valid = SPI_FSM_Done_i && !start_q;
   assign abort      = abort_q || !Enable_i;
   assign dec        = (state == ST_IDLE);
   assign delta      = {1'b0, sample} - {1'b0, value};
   assign magnitude  = delta[16] ? (~delta + 17'd1) : delta;

   always_comb begin
      state_nxt = state;
      start_nxt = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;
      report    = 1'b0;
      case (state)
         ST_DISABLED: begin
            if (Enable_i) begin
               state_nxt = ST_IDLE;
               load      = 1'b1;
            end
         end
         ST_IDLE: begin
            if (!Enable_i) begin
               state_nxt = ST_DISABLED;
            end else if (zero) begin
               state_nxt = ST_XFER;
               start_nxt = 1'b1;
            end
         end
         ST_XFER: begin
            if (done_valid) begin
               if (abort) begin
                  state_nxt = ST_DISABLED;
               end else begin
                  state_nxt = ST_CHECK;
                  capture   = 1'b1;
               end
            end else if (wd_expired) begin
               if (abort) begin
                  state_nxt = ST_DISABLED;
               end else begin
                  state_nxt = ST_IDLE;
                  load      = 1'b1;
               end
            end
         end
         ST_CHECK: begin
            if (!Enable_i) begin
               state_nxt = ST_DISABLED;
            end else begin
               state_nxt = ST_IDLE;
               load      = 1'b1;
               report    = (magnitude > {1'b0, threshold});
            end
         end
         default: state_nxt = ST_DISABLED;
      endcase
   end

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state     <= ST_DISABLED;
         start_q   <= 1'b0;
         intr_q    <= 1'b0;
         abort_q   <= 1'b0;
         sample    <= '0;
         value     <= '0;
         threshold <= '0;
      end else begin
         state   <= state_nxt;
         start_q <= start_nxt;
         intr_q  <= report;
         abort_q <= (state == ST_XFER) && abort;
         if (capture) sample    <= assemble_value(Byte1_i, Byte0_i[7:5]);
         if (report)  value     <= sample;
         if (load)    threshold <= ParamThreshold_i;
      end
   end

`ifdef MAX6682_SPI_TIMEOUT_EN
   localparam int WdWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

   logic [WdWidth-1:0] wd_count;
   logic               spi_timeout;

   assign wd_expired = (state == ST_XFER) && (wd_count == WdWidth'(TimeoutCycles - 1));

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         wd_count    <= '0;
         spi_timeout <= 1'b0;
      end else begin
         wd_count <= (state == ST_XFER) ? wd_count + WdWidth'(1) : '0;
         if (wd_expired && !done_valid) spi_timeout <= 1'b1;
      end
   end

   assign SpiTimeout_o = spi_timeout;
`else
   assign wd_expired   = 1'b0;
   assign SpiTimeout_o = 1'b0;
`endif

   assign SPI_FSM_Start_o = start_q;
   assign CpuIntr_o       = intr_q;
   assign SensorValue_o   = value;

endmodule
`default_nettype wire

// File: tb/tb_max6682_sample_sched.sv
`default_nettype none
// tb_max6682_sample_sched: randomized bench against a transaction-level scheduler model.
module tb_max6682_sample_sched;

   logic        clk = 1'b0;
   logic        rst_n, en, done;
   logic [15:0] preset, thr;
   logic [7:0]  b0, b1;
   logic        start, intr, tmo;
   logic [15:0] value;

   int total = 0;
   int bad   = 0;

   // model state: last reported value and the parameters latched at the last reload
   int m_value  = 0;
   int m_thr    = 0;
   int m_preset = 0;

   always #5 clk = ~clk;

   max6682_sample_sched #(.CntWidth(16), .TimeoutCycles(16)) dut (
      .Clk_i                (clk),
      .Reset_n_i            (rst_n),
      .Enable_i             (en),
      .ParamCounterPreset_i (preset),
      .ParamThreshold_i     (thr),
      .SPI_FSM_Start_o      (start),
      .SPI_FSM_Done_i       (done),
      .Byte0_i              (b0),
      .Byte1_i              (b1),
      .SensorValue_o        (value),
      .CpuIntr_o            (intr),
      .SpiTimeout_o         (tmo)
   );

   function automatic int reading(input int hi, input int lo);
      return hi * 8 + lo / 32;
   endfunction

   function automatic int absdiff(input int a, input int c);
      return (a > c) ? a - c : c - a;
   endfunction

   task automatic model_reload();
      m_preset = int'(preset);
      m_thr    = int'(thr);
   endtask

   task automatic wait_start(output int lat, output int spurious, output bit to);
      lat = 0;
      spurious = 0;
      while (start !== 1'b1 && lat < 5000) begin
         @(negedge clk);
         lat++;
         if (intr !== 1'b0) spurious++;
      end
      to = (start !== 1'b1);
   endtask

   // From a reload point: wait for start, answer with Done after k cycles, load next params.
   task automatic sample_once(input logic [7:0] hi, input logic [7:0] lo, input int k,
                              input logic [15:0] np, input logic [15:0] nt,
                              output int lat, output int spurious, output bit to,
                              output logic sw, output logic i1, output logic i2, output logic [15:0] v2);
      sw = 1'bx; i1 = 1'bx; i2 = 1'bx; v2 = 'x;
      wait_start(lat, spurious, to);
      if (to) return;
      @(negedge clk);
      sw = start;
      repeat (k - 1) @(negedge clk);
      done = 1'b1; b1 = hi; b0 = lo; preset = np; thr = nt;
      @(negedge clk);
      done = 1'b0; b0 = 8'($urandom); b1 = 8'($urandom);
      i1 = intr;
      @(negedge clk);
      i2 = intr;
      v2 = value;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; done = 1'b0; preset = '0; thr = '0; b0 = '0; b1 = '0;
      repeat (3) @(negedge clk);
      total++; if (start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start); end
      total++; if (intr !== 1'b0) begin bad++; $display("FAIL reset_intr: got %b want 0", intr); end
      total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value: got %h want 0000", value); end
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", tmo); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      total++; if (start !== 1'b0) begin bad++; $display("FAIL disabled_start: got %b want 0", start); end
   endtask

   task automatic test_directed();
      logic [7:0]  hi_t [4];
      logic [7:0]  lo_t [4];
      logic [15:0] np_t [4];
      logic [15:0] nt_t [4];
      logic        ei_t [4];
      logic [15:0] ev_t [4];
      int lat, sp; bit to; logic sw, i1, i2; logic [15:0] v2;
      hi_t = '{8'h12, 8'h13, 8'h13, 8'h10};
      lo_t = '{8'hA0, 8'h40, 8'h60, 8'h1F};
      np_t = '{16'd0, 16'd2, 16'd3, 16'd1};
      nt_t = '{16'd5, 16'd5, 16'd4, 16'd7};
      ei_t = '{1'b1, 1'b0, 1'b1, 1'b1};
      ev_t = '{16'h0095, 16'h0095, 16'h009B, 16'h0080};
      preset = 16'd4; thr = 16'd0;
      en = 1'b1;
      @(negedge clk);
      model_reload();
      for (int i = 0; i < 4; i++) begin
         sample_once(hi_t[i], lo_t[i], 1 + i, np_t[i], nt_t[i], lat, sp, to, sw, i1, i2, v2);
         total++; if (to) begin bad++; $display("FAIL dir_start_timeout[%0d]: no start within %0d cycles", i, lat); end
         total++; if (lat != ((i == 0) ? 5 : m_preset + 1)) begin bad++; $display("FAIL dir_start_latency[%0d]: got %0d want %0d", i, lat, (i == 0) ? 5 : m_preset + 1); end
         total++; if (sw !== 1'b0) begin bad++; $display("FAIL dir_start_width[%0d]: second cycle start=%b want 0", i, sw); end
         total++; if (i1 !== 1'b0) begin bad++; $display("FAIL dir_intr_early[%0d]: got %b want 0", i, i1); end
         total++; if (i2 !== ei_t[i]) begin bad++; $display("FAIL dir_intr[%0d]: got %b want %b", i, i2, ei_t[i]); end
         total++; if (v2 !== ev_t[i]) begin bad++; $display("FAIL dir_value[%0d]: got %h want %h", i, v2, ev_t[i]); end
         total++; if (sp != 0) begin bad++; $display("FAIL dir_intr_width[%0d]: %0d stray intr cycles want 0", i, sp); end
         if (absdiff(reading(hi_t[i], lo_t[i]), m_value) > m_thr) m_value = reading(hi_t[i], lo_t[i]);
         model_reload();
      end
   endtask

   task automatic test_done_in_start_cycle();
      int lat, sp, ni, nv; bit to; logic exp_i;
      wait_start(lat, sp, to);
      total++; if (to || lat != m_preset + 1) begin bad++; $display("FAIL sc_start_latency: got %0d want %0d", lat, m_preset + 1); end
      done = 1'b1; b1 = 8'hFF; b0 = 8'hE0;
      ni = 0;
      @(negedge clk); done = 1'b0; if (intr !== 1'b0) ni++;
      @(negedge clk); if (intr !== 1'b0) ni++;
      @(negedge clk); if (intr !== 1'b0) ni++;
      nv = (m_value + 100) % 2048;
      done = 1'b1; b1 = 8'(nv / 8); b0 = 8'((nv % 8) * 32 + 5); preset = 16'd2; thr = 16'd1;
      @(negedge clk); done = 1'b0; if (intr !== 1'b0) ni++;
      exp_i = (absdiff(nv, m_value) > m_thr);
      if (exp_i) m_value = nv;
      @(negedge clk);
      total++; if (ni != 0) begin bad++; $display("FAIL sc_ignored_done: %0d intr cycles want 0", ni); end
      total++; if (intr !== exp_i) begin bad++; $display("FAIL sc_intr: got %b want %b", intr, exp_i); end
      total++; if (value !== 16'(m_value)) begin bad++; $display("FAIL sc_value: got %h want %h", value, 16'(m_value)); end
      model_reload();
   endtask

   task automatic test_disable_in_xfer();
      int lat, sp, ns, ni; bit to;
      wait_start(lat, sp, to);
      total++; if (to || lat != m_preset + 1) begin bad++; $display("FAIL dx_start_latency: got %0d want %0d", lat, m_preset + 1); end
      ni = 0; ns = 0;
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      done = 1'b1; b1 = 8'hFF; b0 = 8'hE0;
      @(negedge clk); done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (start !== 1'b0) ns++;
         if (intr !== 1'b0) ni++;
      end
      total++; if (ns != 0) begin bad++; $display("FAIL dx_start: %0d start cycles want 0", ns); end
      total++; if (ni != 0) begin bad++; $display("FAIL dx_intr: %0d intr cycles want 0", ni); end
      total++; if (value !== 16'(m_value)) begin bad++; $display("FAIL dx_value: got %h want %h", value, 16'(m_value)); end
      preset = 16'd20; thr = 16'd3; en = 1'b1;
      @(negedge clk);
      model_reload();
   endtask

   task automatic test_disable_in_idle();
      int ns;
      ns = 0;
      repeat (3) @(negedge clk);
      en = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (start !== 1'b0) ns++;
      end
      total++; if (ns != 0) begin bad++; $display("FAIL di_start: %0d start cycles want 0", ns); end
      preset = 16'($urandom_range(0, 6)); thr = 16'($urandom_range(0, 25)); en = 1'b1;
      @(negedge clk);
      model_reload();
   endtask

   task automatic test_random();
      int lat, sp, nv, k; bit to; logic sw, i1, i2, exp_i; logic [15:0] v2, np, nt;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 3) == 0) nv = $urandom_range(0, 2047);
         else nv = m_value + $urandom_range(0, 40) - 20;
         if (nv < 0) nv = 0;
         if (nv > 2047) nv = 2047;
         k  = $urandom_range(1, 5);
         np = 16'($urandom_range(0, 6));
         nt = 16'($urandom_range(0, 25));
         sample_once(8'(nv / 8), 8'((nv % 8) * 32 + $urandom_range(0, 31)), k, np, nt,
                     lat, sp, to, sw, i1, i2, v2);
         exp_i = (absdiff(nv, m_value) > m_thr);
         if (exp_i) m_value = nv;
         total++; if (to || lat != m_preset + 1) begin bad++; $display("FAIL rnd_start_latency[%0d]: got %0d want %0d", n, lat, m_preset + 1); end
         total++; if (sw !== 1'b0 || i1 !== 1'b0 || sp != 0) begin bad++; $display("FAIL rnd_pulse_width[%0d]: start2=%b intr_early=%b stray=%0d want 0/0/0", n, sw, i1, sp); end
         total++; if (i2 !== exp_i) begin bad++; $display("FAIL rnd_intr[%0d]: got %b want %b", n, i2, exp_i); end
         total++; if (v2 !== 16'(m_value)) begin bad++; $display("FAIL rnd_value[%0d]: got %h want %h", n, v2, 16'(m_value)); end
         model_reload();
      end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0; en = 1'b0;
      #1;
      total++; if (value !== 16'h0000) begin bad++; $display("FAIL async_value: got %h want 0000", value); end
      total++; if (intr !== 1'b0 || start !== 1'b0) begin bad++; $display("FAIL async_pulses: intr=%b start=%b want 0/0", intr, start); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_value = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int lat, sp, ns, nt; bit to;
      preset = 16'd3; thr = 16'd0; en = 1'b1;
      @(negedge clk);
      model_reload();
      wait_start(lat, sp, to);
      total++; if (to || lat != 4) begin bad++; $display("FAIL to_start_latency: got %0d want 4", lat); end
`ifdef MAX6682_SPI_TIMEOUT_EN
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         if (j == 15) begin
            total++; if (tmo !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", tmo); end
         end
      end
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", tmo); end
      wait_start(lat, sp, to);
      total++; if (to || lat != 4) begin bad++; $display("FAIL to_restart_latency: got %0d want 4", lat); end
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", tmo); end
`else
      ns = 0; nt = 0;
      @(negedge clk);
      repeat (300) begin
         @(negedge clk);
         if (start !== 1'b0) ns++;
         if (tmo !== 1'b0) nt++;
      end
      total++; if (ns != 0) begin bad++; $display("FAIL to_no_restart: %0d start cycles want 0", ns); end
      total++; if (nt != 0) begin bad++; $display("FAIL to_flag_tied: %0d flag cycles want 0", nt); end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_done_in_start_cycle();
      test_disable_in_xfer();
      test_disable_in_idle();
      test_random();
      test_async_reset();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: simulation did not complete, checks so far total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
